// File: rtl/audio_dac_stream.sv
// audio_dac_stream
//   Streams 16-bit stereo PCM frames to the WM8731 DAC data pin. The codec is
//   the bus master (DSP mode, LRP=1, 16-bit), so AUD_BCLK and AUD_DACLRCK
//   arrive asynchronously. They are synchronized into CLOCK_50 and
//   edge-detected. Each LRCK rising edge pops one {left,right} frame from a
//   small FIFO into a 32-bit shifter, MSB first. Each later BCLK falling edge
//   advances the shifter by one bit.
//
//   Build option: AUDIO_DAC_HOLD_ON_UNDERRUN_EN
//     defined   - an underrun replays the last successfully popped frame
//     undefined - an underrun plays silence (32'h0)
//
// Ports
//   CLOCK_50         system clock
//   rst              synchronous active-high reset
//   audio_init_done  codec configured; streaming is held off while low
//   sample_left/right, sample_valid, sample_ready   frame push handshake
//   AUD_BCLK, AUD_DACLRCK   codec bit clock / frame sync (asynchronous)
//   AUD_DACDAT       serial data to the codec
//   fifo_level       number of frames stored
//   underrun         one-cycle pulse: frame sync arrived with the FIFO empty
//   frame_err        one-cycle pulse: frame sync arrived before all 32 bits
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | codec not ready; output low, no pops, pushes still accepted
// ST_WAIT_SYNC | waiting for an LRCK rising edge to load the next frame
// ST_SHIFT     | shifting the loaded frame out on BCLK falling edges

module audio_dac_stream #(
  parameter int FIFO_AW  = 3,
  parameter int SAMPLE_W = 16
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                audio_init_done,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                AUD_BCLK,
  input  logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underrun,
  output logic                frame_err
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_SHIFT     = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Pin synchronizers: [0],[1] are the 2-FF synchronizer, [2] is the delayed
  // copy used for edge detection. They are left out of reset on purpose: the
  // pins keep toggling through a reset, and clearing the chain could fake an
  // LRCK rising edge just after reset if the pin happens to be high.
  // ---------------------------------------------------------------------------
  logic [2:0] bclk_sync_q;
  logic [2:0] lrck_sync_q;
  logic       bclk_fall;
  logic       lrck_rise;

  always_ff @(posedge CLOCK_50) begin
    bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
  end

  assign bclk_fall = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_rise = lrck_sync_q[1] & ~lrck_sync_q[2];

  // ---------------------------------------------------------------------------
  // Frame FIFO
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               sample_ready_q, sample_ready_d;
  logic [FRAME_W-1:0] fifo_rd_data;
  logic               fifo_empty;
  logic               do_push;
  logic               do_pop;

  state_t             state_q, state_d;

  assign fifo_rd_data = fifo_mem_q[rd_ptr_q];
  assign fifo_empty   = (level_q == '0);
  assign do_push      = sample_valid && sample_ready_q;
  // Popping uses the registered level, so a push landing in the same cycle as
  // the frame sync is not visible yet: the pop reports an underrun and the
  // pushed frame simply waits for the next sync.
  assign do_pop       = lrck_rise && audio_init_done &&
                        (state_q != ST_IDLE) && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    sample_ready_d = (level_d != LEVEL_FULL);
  end

  always_ff @(posedge CLOCK_50) begin
    if (do_push) begin
      fifo_mem_q[wr_ptr_q] <= {sample_left, sample_right};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      sample_ready_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      sample_ready_q <= sample_ready_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign fifo_level   = level_q;

  // ---------------------------------------------------------------------------
  // Frame used when the sync finds the FIFO empty
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] underrun_frame;

`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
  logic [FRAME_W-1:0] last_frame_q, last_frame_d;

  always_comb begin
    last_frame_d = last_frame_q;
    if (do_pop) begin
      last_frame_d = fifo_rd_data;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      last_frame_q <= '0;
    end else begin
      last_frame_q <= last_frame_d;
    end
  end

  assign underrun_frame = last_frame_q;
`else
  assign underrun_frame = '0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencer and shifter
  // ---------------------------------------------------------------------------
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               underrun_q, underrun_d;
  logic               frame_err_q, frame_err_d;
  logic               dac_q, dac_d;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;

    if (!audio_init_done) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_SYNC;
        end
        ST_WAIT_SYNC, ST_SHIFT: begin
          // A frame sync always wins over a coincident BCLK edge: the new
          // frame is loaded and its MSB driven, the bit edge is dropped.
          if (lrck_rise) begin
            frame_err_d = (state_q == ST_SHIFT) && (bit_cnt_q < CNT_LAST);
            underrun_d  = fifo_empty;
            shift_d     = fifo_empty ? underrun_frame : fifo_rd_data;
            bit_cnt_d   = CNT_ONE;
            state_d     = ST_SHIFT;
          end else if ((state_q == ST_SHIFT) && bclk_fall) begin
            // bit_cnt counts bits already presented; once the LSB has been
            // held through a falling edge the frame is done.
            if (bit_cnt_q == CNT_LAST) begin
              bit_cnt_d = '0;
              state_d   = ST_WAIT_SYNC;
            end else begin
              shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Separate output register keeps the pin-to-data latency at a fixed four
    // cycles and forces the line low outside of SHIFT.
    dac_d = audio_init_done && (state_q == ST_SHIFT) && shift_q[FRAME_W-1];
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      dac_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
      dac_q       <= dac_d;
    end
  end

  assign AUD_DACDAT = dac_q;
  assign underrun   = underrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_audio_dac_stream.sv
// Testbench for audio_dac_stream. A queue-based reference model tracks the FIFO
// contents and the frame/bit position being played. The expected DACDAT bit
// around every codec pin event is derived from that model.
module tb_audio_dac_stream;

  localparam int DEPTH = 8;
`ifdef AUDIO_DAC_HOLD_ON_UNDERRUN_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        rst = 1'b1;
  logic        audio_init_done = 1'b0;
  logic [15:0] sample_left = '0;
  logic [15:0] sample_right = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        AUD_BCLK = 1'b1;
  logic        AUD_DACLRCK = 1'b0;
  logic        AUD_DACDAT;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic        frame_err;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_dac_stream #(.FIFO_AW(3), .SAMPLE_W(16)) dut (
    .CLOCK_50        (CLOCK_50),
    .rst             (rst),
    .audio_init_done (audio_init_done),
    .sample_left     (sample_left),
    .sample_right    (sample_right),
    .sample_valid    (sample_valid),
    .sample_ready    (sample_ready),
    .AUD_BCLK        (AUD_BCLK),
    .AUD_DACLRCK     (AUD_DACLRCK),
    .AUD_DACDAT      (AUD_DACDAT),
    .fifo_level      (fifo_level),
    .underrun        (underrun),
    .frame_err       (frame_err)
  );

  int checks = 0;
  int failures = 0;

  // reference model
  logic [31:0] model_q [$];
  logic [31:0] cur_frame = '0;
  logic [31:0] last_pop = '0;
  bit          active = 1'b0;
  int          nfall = 0;
  bit          init_on = 1'b0;

  typedef struct {
    bit          valid;
    logic [31:0] frame;
    int          exp_level;
    bit          exp_ready;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_dac();
    return active ? cur_frame[31 - nfall] : 1'b0;
  endfunction

  task automatic push_frame(input logic [31:0] f);
    bit acc;
    acc = (model_q.size() < DEPTH);
    sample_valid = 1'b1;
    {sample_left, sample_right} = f;
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
    if (acc) model_q.push_back(f);
  endtask

  task automatic set_init(input bit v);
    audio_init_done = v;
    init_on = v;
    if (!v) active = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    if (!v) check("dac_low_when_not_init", AUD_DACDAT, 1'b0);
  endtask

  // LRCK rising edge, optionally with a simultaneous BCLK fall and/or a push
  // landing in the same cycle as the frame load.
  task automatic lrck_event(input bit with_fall, input bit push_mid, input logic [31:0] pfrm);
    logic prev_bit, new_bit;
    bit   exp_u, exp_f, acc;
    int   nu, nf;
    prev_bit = exp_dac();
    acc = (model_q.size() < DEPTH);
    exp_u = 1'b0; exp_f = 1'b0; nu = 0; nf = 0;
    if (init_on) begin
      exp_f = active && (nfall < 31);
      if (model_q.size() > 0) begin
        cur_frame = model_q.pop_front();
        last_pop = cur_frame;
      end else begin
        exp_u = 1'b1;
        cur_frame = HOLD ? last_pop : 32'h0;
      end
      active = 1'b1;
      nfall = 0;
    end
    if (push_mid && acc) model_q.push_back(pfrm);
    new_bit = exp_dac();
    AUD_DACLRCK = 1'b1;
    if (with_fall) AUD_BCLK = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      if (underrun) nu++;
      if (frame_err) nf++;
      if (i == 3) begin
        check("lrck_dac_before", AUD_DACDAT, prev_bit);
        check("underrun_at_load", underrun, exp_u);
        check("frame_err_at_load", frame_err, exp_f);
      end
      if (i == 4) check("lrck_dac_after", AUD_DACDAT, new_bit);
      if (push_mid && i == 2) begin
        sample_valid = 1'b1;
        {sample_left, sample_right} = pfrm;
      end
      if (push_mid && i == 3) sample_valid = 1'b0;
    end
    check("underrun_pulse_count", nu, exp_u);
    check("frame_err_pulse_count", nf, exp_f);
    AUD_DACLRCK = 1'b0;
    AUD_BCLK = 1'b1;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic bclk_fall_event();
    logic prev_bit, new_bit;
    int   stray;
    prev_bit = exp_dac();
    stray = 0;
    if (active) begin
      if (nfall == 31) active = 1'b0;
      else nfall++;
    end
    new_bit = exp_dac();
    AUD_BCLK = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      if (underrun || frame_err) stray++;
      if (i == 3) check("bit_dac_before", AUD_DACDAT, prev_bit);
      if (i == 4) check("bit_dac_after", AUD_DACDAT, new_bit);
    end
    check("no_pulse_on_bclk", stray, 0);
    AUD_BCLK = 1'b1;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic falls(input int n);
    for (int k = 0; k < n; k++) bclk_fall_event();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge CLOCK_50);
    check("rst_level", fifo_level, 0);
    check("rst_dac", AUD_DACDAT, 1'b0);
    check("rst_ready", sample_ready, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    model_q.delete();
    active = 1'b0;
    nfall = 0;
    last_pop = '0;
    @(negedge CLOCK_50);
    check("ready_after_rst", sample_ready, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 9; i++) begin
      vecs[i].valid     = 1'b1;
      vecs[i].frame     = 32'hA500_0000 | 32'(i);
      vecs[i].exp_level = (i < 8) ? i + 1 : 8;
      vecs[i].exp_ready = (i < 7);
    end
    vecs[9].valid     = 1'b0;
    vecs[9].frame     = 32'hDEAD_BEEF;
    vecs[9].exp_level = 8;
    vecs[9].exp_ready = 1'b0;

    // power-up reset
    repeat (3) @(negedge CLOCK_50);
    reset_pulse();

    // single known frame, bit-by-bit
    set_init(1'b1);
    push_frame({16'h8001, 16'h7FFE});
    check("level_one", fifo_level, 1);
    lrck_event(1'b0, 1'b0, '0);
    falls(32);
    check("dac_zero_after_frame", AUD_DACDAT, 1'b0);

    // underrun: silence or replay of previous frame
    push_frame(32'h1234_5678);
    lrck_event(1'b0, 1'b0, '0);
    falls(32);
    lrck_event(1'b0, 1'b0, '0);
    falls(32);

    // fill while codec not ready
    set_init(1'b0);
    for (int i = 0; i < 10; i++) begin
      bit acc;
      acc = (model_q.size() < DEPTH);
      sample_valid = vecs[i].valid;
      {sample_left, sample_right} = vecs[i].frame;
      @(negedge CLOCK_50);
      if (vecs[i].valid && acc) model_q.push_back(vecs[i].frame);
      check("fill_level", fifo_level, vecs[i].exp_level);
      check("fill_ready", sample_ready, vecs[i].exp_ready);
    end
    sample_valid = 1'b0;
    lrck_event(1'b0, 1'b0, '0);
    falls(3);
    lrck_event(1'b0, 1'b0, '0);
    check("no_pop_when_idle", fifo_level, 8);

    set_init(1'b1);
    lrck_event(1'b0, 1'b0, '0);
    check("level_after_pop", fifo_level, 7);
    check("ready_after_pop", sample_ready, 1'b1);

    // truncated frame, then LRCK coincident with a BCLK fall
    falls(20);
    lrck_event(1'b0, 1'b0, '0);
    falls(5);
    lrck_event(1'b1, 1'b0, '0);
    falls(32);

    // reset in the middle of a frame, then resume
    lrck_event(1'b0, 1'b0, '0);
    falls(10);
    reset_pulse();
    check("dac_after_mid_rst", AUD_DACDAT, 1'b0);
    lrck_event(1'b0, 1'b1, 32'hCAFE_F00D);
    check("push_during_underrun_kept", fifo_level, 1);
    falls(32);
    lrck_event(1'b0, 1'b0, '0);
    falls(32);

    // randomized traffic
    for (int r = 0; r < 12; r++) begin
      int np, nb;
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) push_frame($urandom);
      check("rand_level", fifo_level, model_q.size());
      check("rand_ready", sample_ready, model_q.size() < DEPTH);
      lrck_event(1'b0, 1'b0, '0);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 32;
      falls(nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_dac_stream.md
# audio_dac_stream

Streams 16-bit stereo PCM to the WM8731 DAC data pin once the audio chip init block has configured the codec as master, DSP mode, LRP=1, 16-bit (R7 = 0x053). Samples from the synthesis/playback logic are buffered in a small frame FIFO and shifted out on AUD_DACDAT, aligned to the codec-driven AUD_BCLK/AUD_DACLRCK. The block sits directly downstream of the init block and is gated by its audio_init_done output.

## Interface
- FIFO_AW, 3, log2 of FIFO depth in stereo frames (default 8 frames of 32 bits)
- SAMPLE_W, 16, bits per channel; must match codec IWL (16)

- CLOCK_50  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- audio_init_done  in  1  high once codec is configured; streaming disabled while low
- sample_left  in  SAMPLE_W  left sample, two's complement
- sample_right  in  SAMPLE_W  right sample, two's complement
- sample_valid  in  1  frame offered this cycle
- sample_ready  out  1  FIFO can accept a frame
- AUD_BCLK  in  1  codec bit clock (asynchronous)
- AUD_DACLRCK  in  1  codec frame sync (asynchronous)
- AUD_DACDAT  out  1  serial data to codec
- fifo_level  out  FIFO_AW+1  frames stored
- underrun  out  1  one-cycle pulse: frame sync with empty FIFO
- frame_err  out  1  one-cycle pulse: frame sync before 32 bits shifted

## Operation
- AUD_BCLK, AUD_DACLRCK each pass a 2-FF synchronizer, then a third register for edge detect.
- FIFO: 2^FIFO_AW entries of {left,right}. Push when sample_valid && sample_ready. sample_ready = !full. Push and pop in the same cycle both occur; level unchanged.
- Pop occurs only on a detected AUD_DACLRCK rising edge while in WAIT_SYNC or SHIFT.
- States:
  - IDLE: AUD_DACDAT=0; no pops; FIFO still accepts pushes. -> WAIT_SYNC when audio_init_done=1.
  - WAIT_SYNC: on LRCK rising edge, load 32-bit shifter with popped frame (left in [31:16]), drive bit 31, bit_cnt=1 -> SHIFT.
  - SHIFT: each BCLK falling edge shifts left, drives next bit, bit_cnt++. After bit 0 has been held through one falling edge (bit_cnt=32), AUD_DACDAT=0 -> WAIT_SYNC.
  - Any state: audio_init_done=0 -> IDLE at next cycle, AUD_DACDAT=0.
- LRCK rising edge in SHIFT with bit_cnt<32: pulse frame_err, abandon frame, load next frame as in WAIT_SYNC.
- LRCK rising edge with FIFO empty: pulse underrun, load 32'h0 (or per Configuration), still enter SHIFT.
- LRCK rising edge and BCLK falling edge detected in the same cycle: LRCK load wins.
- Push to empty FIFO in the same cycle as an LRCK edge: pop sees empty (underrun); pushed frame retained.

## Timing
- Reset (rst high at a CLOCK_50 edge): state IDLE, FIFO pointers 0, fifo_level=0, AUD_DACDAT=0, underrun=0, frame_err=0, sample_ready=0 during reset, 1 on the first cycle after rst drops.
- Pin edge to AUD_DACDAT update: 4 CLOCK_50 cycles (2 sync + 1 detect + 1 output register), fixed.
- Requirement: BCLK low and high phases each >= 6 CLOCK_50 cycles, so data settles before the codec samples on the BCLK rising edge.
- fifo_level and sample_ready update the cycle after push/pop.
- underrun and frame_err assert one cycle, coincident with the shifter load.

## Configuration
- AUDIO_DAC_HOLD_ON_UNDERRUN_EN defined: on underrun the shifter reloads the last successfully popped frame (0 if none since reset); underrun still pulses.
- Not defined: underrun loads 32'h0 (silence).

## Test plan
- Reset then push {16'h8001,16'h7FFE}, init_done=1, LRCK pulse, 32 BCLKs -> DACDAT bits 1000_0000_0000_0001_0111_1111_1111_1110, each valid 4 cycles after BCLK falling edge, then 0.
- Push 8 frames with no LRCK -> fifo_level=8, sample_ready=0; 9th valid ignored; one LRCK edge -> level 7, ready=1.
- LRCK edge with empty FIFO -> underrun one-cycle pulse; DACDAT all 0 (macro off) or previous frame 0x12345678 repeated (macro on).
- LRCK edge after 20 BCLKs of a frame -> frame_err pulse, next frame MSB driven 4 cycles later.
- audio_init_done=0 with 3 frames queued and LRCK running -> no pops, level stays 3, DACDAT=0.
- rst asserted mid-frame for one cycle -> next cycle level=0, DACDAT=0, state IDLE; resumes on next LRCK edge.
